// File: rtl/arb_req_queue_pkg.sv
// rtl/arb_req_queue_pkg.sv - shared constants and helpers for the arbitrated request queue
//
// Purpose: channel count, default geometry, channel index type and the
//          one-hot test used by the grant decoder.
// Ports:   none (package).
package arb_req_queue_pkg;

  localparam int NUM_CH    = 3;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;
  localparam int CH_W      = 2;

  typedef logic [CH_W-1:0] ch_idx_t;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [NUM_CH-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/arb_req_queue_if.sv
// rtl/arb_req_queue_if.sv - push, arbiter and output bundle of the arbitrated request queue
//
// Purpose: groups every non-clock/reset signal of arb_req_queue.
// Signals: in_vld/in_rdy/in_data  per-channel push handshake (channel i = bit i / slice i)
//          req_vld/grant           request to and one-hot grant from the arbiter
//          out_vld/out_ch/out_data granted entry, no backpressure
//          grant_err               sticky bad-grant flag
//          level                   per-channel occupancy, LW bits per channel
// Modports: master = producer/arbiter side, slave = queue side.
interface arb_req_queue_if
  import arb_req_queue_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) ();

  localparam int LW = $clog2(DEPTH) + 1;

  logic [NUM_CH-1:0]    in_vld;
  logic [NUM_CH-1:0]    in_rdy;
  logic [NUM_CH*DW-1:0] in_data;
  logic [NUM_CH-1:0]    req_vld;
  logic [NUM_CH-1:0]    grant;
  logic                 out_vld;
  logic [CH_W-1:0]      out_ch;
  logic [DW-1:0]        out_data;
  logic                 grant_err;
  logic [NUM_CH*LW-1:0] level;

  modport master (
    output in_vld, in_data, grant,
    input  in_rdy, req_vld, out_vld, out_ch, out_data, grant_err, level
  );

  modport slave (
    input  in_vld, in_data, grant,
    output in_rdy, req_vld, out_vld, out_ch, out_data, grant_err, level
  );

endinterface

// File: rtl/arb_req_fifo.sv
// rtl/arb_req_fifo.sv - single-channel synchronous FIFO for the arbitrated request queue
//
// Purpose: DEPTH-entry FIFO (DEPTH a power of two, >= 2) with a show-ahead head.
// Ports:   clk, rst      clock, synchronous active-high reset
//          push/push_data write at tail; ignored when full (no pop bypass)
//          pop            drop head; ignored when empty
//          head           current head entry (valid when !empty)
//          level          occupancy 0..DEPTH
//          full/empty     occupancy flags
module arb_req_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              head,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign level   = cnt;

  // Storage carries no reset; only pointers and count are control state.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/arb_req_queue.sv
// rtl/arb_req_queue.sv - three-channel request queue feeding a registered round-robin arbiter
//
// Purpose: one FIFO per channel; raises per-channel requests, pops the
//          granted head and registers it onto the output.
// Ports:   clk  clock, rising edge
//          rst  synchronous active-high reset
//          bus  arb_req_queue_if.slave (push handshake, req/grant, output,
//               grant_err, level)
module arb_req_queue
  import arb_req_queue_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  arb_req_queue_if.slave bus
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [DW-1:0]     head [NUM_CH];
  logic [LW-1:0]     lvl  [NUM_CH];

  logic              grant_onehot;
  logic              err_hit;
  ch_idx_t           sel_ch;
  logic [DW-1:0]     sel_data;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign push[i]                 = bus.in_vld[i] && !full[i];
    assign bus.in_rdy[i]           = !full[i];
    assign bus.level[i*LW +: LW]   = lvl[i];
    // Drop the request while the grant for the last entry is in flight:
    // the arbiter only sees this next cycle and would otherwise over-grant.
    assign bus.req_vld[i]          = lvl[i] > {{(LW-1){1'b0}}, bus.grant[i]};

    arb_req_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data (bus.in_data[i*DW +: DW]),
      .pop       (pop[i]),
      .head      (head[i]),
      .level     (lvl[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

  // Grant decode: only a one-hot grant to a non-empty channel pops.
  // Any grant that is not one-hot, or that targets an empty channel, is an error.
  always_comb begin
    grant_onehot = is_onehot(bus.grant);
    pop          = grant_onehot ? (bus.grant & ~empty) : '0;
    err_hit      = (bus.grant != '0) &&
                   (!grant_onehot || ((bus.grant & empty) != '0));
    sel_ch       = '0;
    sel_data     = head[0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (pop[i]) begin
        sel_ch   = ch_idx_t'(i);
        sel_data = head[i];
      end
    end
  end

  // Output register; out_ch/out_data hold when nothing pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_vld   <= 1'b0;
      bus.out_ch    <= '0;
      bus.out_data  <= '0;
      bus.grant_err <= 1'b0;
    end else begin
      bus.out_vld <= |pop;
      if (|pop) begin
        bus.out_ch   <= sel_ch;
        bus.out_data <= sel_data;
      end
      if (err_hit) begin
        bus.grant_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arb_req_queue.sv
// tb/tb_arb_req_queue.sv - directed self-checking bench for arb_req_queue
module tb_arb_req_queue;
  import arb_req_queue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb_req_queue_if #(.DW(8), .DEPTH(4)) bus ();

  arb_req_queue #(.DW(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic       arb_en;
  logic [2:0] req_s;
  int         last_ch;
  int         idx;

  // Arbiter model samples the request mid-cycle, grants one cycle later.
  always @(negedge clk) req_s <= bus.req_vld;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] rr_pick(input logic [2:0] req, input int last);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (last + k) % 3;
      if (req[c]) return 3'(1 << c);
    end
    return 3'b000;
  endfunction

  function automatic logic [2:0] lvl(input int ch);
    logic [8:0] l;
    l = bus.level;
    return l[ch*3 +: 3];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    if (arb_en) begin
      bus.grant = rr_pick(req_s, last_ch);
      for (int c = 0; c < 3; c++) if (bus.grant[c]) last_ch = c;
    end
  endtask

  task automatic push_ch(input int ch, input logic [7:0] d);
    bus.in_data[ch*8 +: 8] = d;
    bus.in_vld = 3'(1 << ch);
    tick();
    bus.in_vld = 3'b000;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.in_vld = '0;
    bus.in_data = '0;
    bus.grant = '0;
    arb_en = 1'b0;
    last_ch = 2;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_in_rdy", bus.in_rdy, 3'b111);
    check_eq("rst_req_vld", bus.req_vld, 3'b000);
    check_eq("rst_out_vld", bus.out_vld, 1'b0);
    check_eq("rst_out_ch", bus.out_ch, 2'd0);
    check_eq("rst_out_data", bus.out_data, 8'h00);
    check_eq("rst_grant_err", bus.grant_err, 1'b0);
    check_eq("rst_level", bus.level, 9'h000);

    // Single entry on ch0 through the arbiter model.
    arb_en = 1'b1;
    bus.in_data[7:0] = 8'hA1;
    bus.in_vld = 3'b001;
    tick();
    bus.in_vld = 3'b000;
    #1;
    check_eq("c0_req", bus.req_vld, 3'b001);
    check_eq("c0_level", lvl(0), 3'd1);
    tick();
    #1;
    check_eq("c0_req_in_grant", bus.req_vld, 3'b000);
    tick();
    #1;
    check_eq("c0_out_vld", bus.out_vld, 1'b1);
    check_eq("c0_out_ch", bus.out_ch, 2'd0);
    check_eq("c0_out_data", bus.out_data, 8'hA1);
    check_eq("c0_req_after", bus.req_vld, 3'b000);

    // Two entries on ch1, back-to-back grants.
    bus.in_data[15:8] = 8'h11;
    bus.in_vld = 3'b010;
    tick();
    bus.in_data[15:8] = 8'h12;
    tick();
    bus.in_vld = 3'b000;
    #1;
    check_eq("c1_level2", lvl(1), 3'd2);
    check_eq("c1_req", bus.req_vld, 3'b010);
    tick();
    #1;
    check_eq("c1_out0_vld", bus.out_vld, 1'b1);
    check_eq("c1_out0_ch", bus.out_ch, 2'd1);
    check_eq("c1_out0_data", bus.out_data, 8'h11);
    check_eq("c1_req_last", bus.req_vld, 3'b000);
    tick();
    #1;
    check_eq("c1_out1_vld", bus.out_vld, 1'b1);
    check_eq("c1_out1_data", bus.out_data, 8'h12);
    check_eq("c1_level0", lvl(1), 3'd0);
    tick();
    #1;
    check_eq("c1_idle_vld", bus.out_vld, 1'b0);
    check_eq("c1_no_err", bus.grant_err, 1'b0);

    // Fill ch2, push while full is dropped, then drain in order.
    arb_en = 1'b0;
    bus.grant = 3'b000;
    for (int k = 0; k < 4; k++) push_ch(2, 8'(8'hC0 + k));
    bus.in_data[23:16] = 8'hFF;
    bus.in_vld = 3'b100;
    #1;
    check_eq("c2_full_rdy", bus.in_rdy[2], 1'b0);
    check_eq("c2_full_level", lvl(2), 3'd4);
    tick();
    bus.in_vld = 3'b000;
    #1;
    check_eq("c2_level_after_drop", lvl(2), 3'd4);
    arb_en = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      #1;
      if (bus.out_vld && bus.out_ch == 2'd2) begin
        check_eq("c2_drain_data", bus.out_data, 32'(8'hC0 + idx));
        idx++;
      end
    end
    check_eq("c2_drain_count", idx, 4);
    check_eq("c2_level_empty", lvl(2), 3'd0);
    arb_en = 1'b0;
    bus.grant = 3'b000;

    // Grant to an empty channel.
    bus.grant = 3'b010;
    tick();
    bus.grant = 3'b000;
    #1;
    check_eq("gerr_set", bus.grant_err, 1'b1);
    check_eq("gerr_out_vld", bus.out_vld, 1'b0);
    tick();
    tick();
    #1;
    check_eq("gerr_sticky", bus.grant_err, 1'b1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("gerr_cleared", bus.grant_err, 1'b0);

    // Non-one-hot grant pops nothing.
    push_ch(0, 8'h31);
    push_ch(0, 8'h32);
    push_ch(1, 8'h41);
    bus.grant = 3'b011;
    tick();
    bus.grant = 3'b000;
    #1;
    check_eq("multi_err", bus.grant_err, 1'b1);
    check_eq("multi_out_vld", bus.out_vld, 1'b0);
    check_eq("multi_level", bus.level, {3'd0, 3'd1, 3'd2});

    // Same-cycle push and pop on ch0 at level 2.
    bus.in_data[7:0] = 8'h33;
    bus.in_vld = 3'b001;
    bus.grant = 3'b001;
    tick();
    bus.in_vld = 3'b000;
    bus.grant = 3'b000;
    #1;
    check_eq("pp_level", lvl(0), 3'd2);
    check_eq("pp_out_vld", bus.out_vld, 1'b1);
    check_eq("pp_out_ch", bus.out_ch, 2'd0);
    check_eq("pp_out_data", bus.out_data, 8'h31);
    bus.grant = 3'b001;
    tick();
    #1;
    check_eq("pp_out2", bus.out_data, 8'h32);
    tick();
    bus.grant = 3'b000;
    #1;
    check_eq("pp_out3", bus.out_data, 8'h33);
    check_eq("pp_level0", lvl(0), 3'd0);
    bus.grant = 3'b010;
    tick();
    bus.grant = 3'b000;
    #1;
    check_eq("c1b_out_ch", bus.out_ch, 2'd1);
    check_eq("c1b_out_data", bus.out_data, 8'h41);
    tick();
    #1;
    check_eq("hold_out_vld", bus.out_vld, 1'b0);
    check_eq("hold_out_ch", bus.out_ch, 2'd1);
    check_eq("hold_out_data", bus.out_data, 8'h41);

    // Load all channels, reset mid-drain.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_data = {8'h21, 8'h11, 8'h01};
    bus.in_vld = 3'b111;
    tick();
    bus.in_data = {8'h22, 8'h12, 8'h02};
    tick();
    bus.in_vld = 3'b000;
    #1;
    check_eq("mid_level", bus.level, {3'd2, 3'd2, 3'd2});
    arb_en = 1'b1;
    tick();
    tick();
    arb_en = 1'b0;
    bus.grant = 3'b000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_level", bus.level, 9'h000);
    check_eq("mid_rst_out_vld", bus.out_vld, 1'b0);
    check_eq("mid_rst_req", bus.req_vld, 3'b000);
    check_eq("mid_rst_in_rdy", bus.in_rdy, 3'b111);
    bus.grant = 3'b001;
    tick();
    bus.grant = 3'b000;
    #1;
    check_eq("post_rst_gerr", bus.grant_err, 1'b1);
    check_eq("post_rst_out_vld", bus.out_vld, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_req_queue.md
ARB_REQ_QUEUE -- requirements
Module: arb_req_queue

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning per-entry data width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning per-channel queue depth (power of two).
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have ports in_vld  input  3, in_rdy  output  3, and in_data  input  3*DW; these form the per-channel push handshake (channel i uses bits i and slice i).
REQ-006 The block SHALL have ports req_vld  output  3 and grant  input  3; these are the request and one-hot grant to and from the round-robin arbiter.
REQ-007 The block SHALL have ports out_vld  output  1, out_ch  output  2, and out_data  output  DW; these carry the granted entry, with no backpressure.
REQ-008 The block SHALL have ports grant_err  output  1 (sticky: grant to a channel with no entry) and level  output  3*($clog2(DEPTH)+1) (per-channel occupancy).

Function
REQ-009 Push on channel i SHALL occur when in_vld[i] && in_rdy[i]; in_rdy[i] = (level[i] < DEPTH), with no same-cycle pop bypass.
REQ-010 req_vld[i] SHALL be combinational: level[i] > grant[i] (1-bit grant extended). This lowers the request during the grant cycle of the last entry, because the arbiter registers its grant one cycle after sampling the request.
REQ-011 Grant is visible in cycle t+1 for a request sampled at the edge ending cycle t; the block SHALL accept a grant in any cycle regardless of the current req_vld.
REQ-012 On grant[i]=1 with level[i]>0, the block SHALL pop the head of channel i at that edge; in the next cycle, out_vld=1, out_ch=i, and out_data=that head (latency 1 from grant).
REQ-013 On grant[i]=1 with level[i]=0, the block SHALL not pop, SHALL hold out_vld=0, and SHALL set grant_err to 1 until reset.
REQ-014 A grant that is not one-hot (two or more bits set) SHALL set grant_err, pop nothing, and drive out_vld=0.
REQ-015 grant=3'b000 SHALL drive out_vld=0 next cycle; out_ch and out_data SHALL hold their last values.
REQ-016 Simultaneous push and pop on the same channel SHALL leave level unchanged; the pushed entry SHALL go to the tail and the head SHALL be output.
REQ-017 A push when full (in_rdy=0) SHALL be ignored, with no data corruption.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH inclusive.
REQ-019 Each channel SHALL be an independent FIFO: order is preserved within a channel, and no ordering is guaranteed across channels.

Reset
REQ-020 While rst=1 at an edge, the block SHALL clear all levels and pointers to 0, set out_vld=0, out_ch=0, out_data=0, and grant_err=0; req_vld is therefore 0 and in_rdy is 3'b111 after reset.
REQ-021 A reset asserted mid-operation SHALL discard all queued entries, and any grant arriving in the cycle after the reset SHALL raise grant_err.
REQ-022 Storage arrays SHALL need no reset; only control state and outputs are reset.

Structure
REQ-023 A shared package SHALL hold NUM_CH=3, the default DW and DEPTH, and the channel index width (2).
REQ-024 One sub-module, arb_req_fifo (sync FIFO with push, pop, data, level, and full/empty), SHALL be instantiated once per channel.
REQ-025 The top SHALL contain only the request logic, the grant decode and error logic, and the output register.

Verification
REQ-026 Bench SHALL cover: push 0xA1 on ch0 only, with the arbiter model granting 1 cycle after each request -> req_vld=001 for one cycle, grant=001, then out_vld=1, out_ch=0, out_data=0xA1, and req_vld=000 from the grant cycle onward.
REQ-027 Bench SHALL cover: push 0x11 and 0x12 on ch1 -> two consecutive grants, outputs 0x11 then 0x12 in order, no grant_err.
REQ-028 Bench SHALL cover: fill ch2 with 4 entries, then drive in_vld[2] with 0xFF -> in_rdy[2]=0, 0xFF dropped, level[2]=4, and all 4 entries drain later in order.
REQ-029 Bench SHALL cover: force grant=010 with level[1]=0 -> grant_err=1 and stays 1; out_vld=0.
REQ-030 Bench SHALL cover: same-cycle push and grant on ch0 at level 2 -> level stays 2 and the head is output.
REQ-031 Bench SHALL cover: ch0, ch1, and ch2 each loaded with 2 entries, then rst for 1 cycle mid-drain -> all levels 0, out_vld=0, req_vld=000 the cycle after the reset.
